// File: rtl/bb_button_reader.sv
// bb_button_reader: synchronise, debounce and count presses of the active-low breakout-board push-button.
// Latency: btn_level/press rise 2+DEBOUNCE_CYCLES edges after the first low sample of nbtn; release is symmetric.
// Backpressure: none; press/rel are single-cycle strobes and count_clr acts on the next edge.
// Optional auto-repeat of press while held is enabled by defining BB_BTN_REPEAT_EN.
// The release strobe port is named rel because "release" is a reserved word in SystemVerilog.
module bb_button_reader #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int RPT_W           = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nbtn,
    input  logic       count_clr,
    output logic       btn_level,
    output logic       press,
    output logic       rel,
    output logic [7:0] count
);

    // Reject parameter sets the counters cannot represent (repeat reload needs PERIOD <= DELAY).
    if (DEBOUNCE_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) > (longint'(1) << DB_W) ||
        REPEAT_PERIOD < 1 ||
        REPEAT_PERIOD > REPEAT_DELAY ||
        longint'(REPEAT_DELAY) > (longint'(1) << RPT_W)) begin : g_bad_params
        $error("bb_button_reader: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    state_t          state;
    logic            s1;
    logic            s2;
    logic            act;
    logic [DB_W-1:0] dcnt;
    logic            accept_press;
    logic            rpt_fire;
    logic            fire;

`ifdef BB_BTN_REPEAT_EN
    // After the first repeat the counter is reloaded so that it reaches the
    // same terminal value again after REPEAT_PERIOD cycles.
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rcnt;
`endif

    assign act = ~s2;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= nbtn;
            s2 <= s1;
        end
    end

    // Decode this cycle's press strobe: debounced accept or an auto-repeat tick.
    always_comb begin
        accept_press = (state == PRESS_WAIT) && act && (dcnt == DB_LAST);
        rpt_fire     = 1'b0;
`ifdef BB_BTN_REPEAT_EN
        rpt_fire     = (state == PRESSED) && act && (rcnt == RPT_FIRST);
`endif
        fire         = accept_press || rpt_fire;
    end

    // Debounce FSM with registered level, strobes and press counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dcnt      <= '0;
            btn_level <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            count     <= '0;
        end else begin
            press <= fire;
            rel   <= 1'b0;

            // A clear coinciding with a press still counts that press.
            if (count_clr) begin
                count <= fire ? 8'd1 : 8'd0;
            end else if (fire) begin
                count <= count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (act) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!act) begin
                        state <= IDLE;
                    end else if (dcnt == DB_LAST) begin
                        state     <= PRESSED;
                        btn_level <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DB_W'(1);
                    end
                end
                PRESSED: begin
                    if (!act) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (act) begin
                        state <= PRESSED;
                    end else if (dcnt == DB_LAST) begin
                        state     <= IDLE;
                        rel       <= 1'b1;
                        btn_level <= 1'b0;
                    end else begin
                        dcnt <= dcnt + DB_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BB_BTN_REPEAT_EN
    // Hold-time counter: runs only while stably pressed, cleared everywhere else,
    // so a bounce back from RELEASE_WAIT restarts the full initial delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
        end else if ((state == PRESSED) && act) begin
            rcnt <= (rcnt == RPT_FIRST) ? RPT_RELOAD : rcnt + RPT_W'(1);
        end else begin
            rcnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_bb_button_reader.sv
// tb_bb_button_reader: directed and randomized stimulus for bb_button_reader against a run-length reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: not applicable; all stimulus is cycle-driven.
module tb_bb_button_reader;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int HOLD = 40;
`ifdef BB_BTN_REPEAT_EN
    localparam int RPT_EXP = 1 + (HOLD - RD) / RP;
`else
    localparam int RPT_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nbtn = 1'b1;
    logic       count_clr = 1'b0;
    logic       btn_level;
    logic       press;
    logic       rel;
    logic [7:0] count;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic       raw_q[$];
    logic       m_level = 1'b0;
    int         m_run = 0;
    int         m_n = 0;
    logic [7:0] m_count = 8'd0;
    logic       exp_press = 1'b0;
    logic       exp_rel = 1'b0;

    int press_seen = 0;
    int rel_seen = 0;
    int lat;
    int seen;

    bb_button_reader #(
        .DEBOUNCE_CYCLES(DEB),
        .DB_W(16),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .RPT_W(25)
    ) dut (
        .clk(clk),
        .rst(rst),
        .nbtn(nbtn),
        .count_clr(count_clr),
        .btn_level(btn_level),
        .press(press),
        .rel(rel),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // Model: the button is seen two edges late; the level flips once it has
    // disagreed with the accepted level on DEB+1 consecutive edges. Repeats
    // are timed from the last edge at which the stable pressed run began.
    task automatic model_edge(input logic nb, input logic clr, input logic r);
        logic a;
        logic strobe;
        strobe    = 1'b0;
        exp_press = 1'b0;
        exp_rel   = 1'b0;
        if (r) begin
            raw_q.delete();
            raw_q.push_back(1'b1);
            raw_q.push_back(1'b1);
            m_level = 1'b0;
            m_run   = 0;
            m_n     = 0;
            m_count = 8'd0;
        end else begin
            raw_q.push_back(nb);
            a = ~raw_q[0];
            void'(raw_q.pop_front());
            if (a != m_level) begin
                m_run++;
                m_n = 0;
                if (m_run == DEB + 1) begin
                    m_level = a;
                    m_run   = 0;
                    if (a) strobe = 1'b1;
                    else exp_rel = 1'b1;
                end
            end else begin
                if (m_level && m_run == 0) begin
                    m_n++;
`ifdef BB_BTN_REPEAT_EN
                    if (m_n == RD || (m_n > RD && (m_n - RD) % RP == 0)) strobe = 1'b1;
`endif
                end else begin
                    m_n = 0;
                end
                m_run = 0;
            end
            if (clr) m_count = strobe ? 8'd1 : 8'd0;
            else if (strobe) m_count = m_count + 8'd1;
            exp_press = strobe;
        end
    endtask

    task automatic step(input logic nb, input logic clr, input logic r);
        nbtn      = nb;
        count_clr = clr;
        rst       = r;
        @(posedge clk);
        model_edge(nb, clr, r);
        #1;
        chk("level", {31'd0, btn_level}, {31'd0, m_level});
        chk("press", {31'd0, press}, {31'd0, exp_press});
        chk("release", {31'd0, rel}, {31'd0, exp_rel});
        chk("count", {24'd0, count}, {24'd0, m_count});
        if (press) press_seen++;
        if (rel) rel_seen++;
    endtask

    initial begin
        // 1. reset with the button held down, then a fresh press after reset
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk("rst_level", {31'd0, btn_level}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (press && lat < 0) lat = i;
        end
        chk("post_rst_lat", lat, 2 + DEB);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);

        // 2. clean press latency and count
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (press && lat < 0) lat = i;
        end
        chk("press_lat", lat, 2 + DEB);
        chk("press_count", {24'd0, count}, 32'd2);

        // 4. release glitch of two cycles is ignored, then a clean release
        rel_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        chk("glitch_norel", rel_seen, 0);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (rel && lat < 0) lat = i;
        end
        chk("release_lat", lat, 2 + DEB);
        chk("release_count", {24'd0, count}, 32'd2);

        // 3. bounce: short low pulses never make a press
        press_seen = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        chk("bounce_nopress", press_seen, 0);
        chk("bounce_level", {31'd0, btn_level}, 32'd0);

        // 5. clear, 256 presses wrap to zero, clear with press, clear alone
        step(1'b1, 1'b1, 1'b0);
        chk("clr_alone", {24'd0, count}, 32'd0);
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        end
        chk("wrap", {24'd0, count}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("clr_with_press", {24'd0, count}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("clr_alone2", {24'd0, count}, 32'd0);

        // 6. long hold: auto-repeat strobes (none extra without the feature)
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (press) lat = i;
        end
        chk("rpt_accept", lat, 2 + DEB);
        seen = 0;
        for (int i = 0; i < HOLD; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (press) seen++;
        end
        chk("rpt_strobes", seen, RPT_EXP);
        chk("rpt_count", {24'd0, count}, 32'(1 + RPT_EXP));
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);

        // reset while held: re-debounced into one fresh press
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        press_seen = 0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        chk("reset_repress", press_seen, 1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);

        // randomized runs of random length with sporadic clears and resets
        for (int b = 0; b < 400; b++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, (b % 4 == 0) ? 40 : 10);
            for (int j = 0; j < len; j++) begin
                step(v, ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
